// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: divides clki to a step tick, synchronises the mode
// switches and steps an off / rotate-left / rotate-right / ping-pong pattern.
module led_seq_ctrl #(
  parameter int DIV = 4,
  parameter int CW  = 32
) (
  input  logic       clki,
  input  logic       rs,
  input  logic       S0,
  input  logic       S1,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_ROL  = 2'b01;
  localparam logic [1:0] M_ROR  = 2'b10;
  localparam logic [1:0] M_PING = 2'b11;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [1:0]    sync1;
  logic [1:0]    ssel;
  logic [CW-1:0] cnt;
  logic          dir;
  logic [7:0]    led_next;
  logic [1:0]    mode_next;
  logic          dir_next;
  logic          onehot;

  function automatic logic [7:0] start_led(input logic [1:0] m);
    case (m)
      M_ROL:   start_led = 8'h01;
      M_ROR:   start_led = 8'h80;
      M_PING:  start_led = 8'h01;
      default: start_led = 8'h00;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      sync1 <= 2'b00;
      ssel  <= 2'b00;
    end else begin
      sync1 <= {S1, S0};
      ssel  <= sync1;
    end
  end

  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      tick <= (cnt == CNT_MAX);
    end
  end

  assign onehot = (led != 8'h00) && ((led & (led - 8'd1)) == 8'h00);

  always_comb begin
    led_next  = led;
    mode_next = mode;
    dir_next  = dir;
    if (tick) begin
      if (ssel != mode) begin
        mode_next = ssel;
        led_next  = start_led(ssel);
        dir_next  = DIR_L;
      end else if (mode != M_OFF && !onehot) begin
        // Corrupted pattern: fall back to the mode's start pattern
        led_next = start_led(mode);
        dir_next = DIR_L;
      end else begin
        case (mode)
          M_ROL: led_next = {led[6:0], led[7]};
          M_ROR: led_next = {led[0], led[7:1]};
          M_PING: begin
            // Bounce at the ends without repeating the endpoint
            if (dir == DIR_L) begin
              if (led[7]) begin
                led_next = 8'h40;
                dir_next = DIR_R;
              end else begin
                led_next = {led[6:0], 1'b0};
              end
            end else begin
              if (led[0]) begin
                led_next = 8'h02;
                dir_next = DIR_L;
              end else begin
                led_next = {1'b0, led[7:1]};
              end
            end
          end
          default: led_next = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clki or posedge rs) begin
    if (rs) begin
      led  <= 8'h00;
      mode <= M_OFF;
      dir  <= DIR_L;
    end else begin
      led  <= led_next;
      mode <= mode_next;
      dir  <= dir_next;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: step-count reference model checked every cycle,
// directed pattern sequences with literal expectations, then random switching.
module tb_led_seq_ctrl;

  localparam int DIV = 4;

  logic       clki = 1'b0;
  logic       rs   = 1'b1;
  logic       S0   = 1'b0;
  logic       S1   = 1'b0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       tick;

  int checks = 0;
  int errors = 0;

  led_seq_ctrl #(.DIV(DIV), .CW(32)) dut (
    .clki(clki), .rs(rs), .S0(S0), .S1(S1),
    .led(led), .mode(mode), .tick(tick)
  );

  always #5 clki = ~clki;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: edge count since reset, switch history, pattern position
  int         n = 0;
  logic [1:0] h0 = 2'b00, h1 = 2'b00;
  logic [1:0] m_mode = 2'b00;
  int         pos = 0, phase = 0;
  logic       m_tick = 1'b0;
  logic [7:0] m_led = 8'h00;

  always @(posedge clki or posedge rs) begin
    if (rs) begin
      n = 0; h0 = 2'b00; h1 = 2'b00; m_mode = 2'b00;
      pos = 0; phase = 0; m_tick = 1'b0; m_led = 8'h00;
    end else begin
      n++;
      if (m_tick) begin
        if (h1 != m_mode) begin
          m_mode = h1;
          pos    = (h1 == 2'b10) ? 7 : 0;
          phase  = 0;
        end else begin
          if (m_mode == 2'b01) pos = (pos + 1) % 8;
          if (m_mode == 2'b10) pos = (pos + 7) % 8;
          phase = (phase + 1) % 14;
        end
        case (m_mode)
          2'b00:   m_led = 8'h00;
          2'b11:   m_led = 8'(1 << ((phase <= 7) ? phase : 14 - phase));
          default: m_led = 8'(1 << pos);
        endcase
      end
      m_tick = (n % DIV == 0);
      h1 = h0;
      h0 = {S1, S0};
    end
  end

  always @(negedge clki) begin
    chk("cyc_led", led, m_led);
    chk("cyc_mode", mode, m_mode);
    chk("cyc_tick", tick, m_tick);
  end

  // Returns at the negedge right after the next step edge
  task automatic wait_step();
    bit found = 0;
    for (int i = 0; i < 3 * DIV && !found; i++) begin
      @(negedge clki);
      if (tick) found = 1;
    end
    if (!found) chk("step_timeout", 0, 1);
    @(negedge clki);
  endtask

  task automatic step_expect(input string nm, input logic [7:0] el, input logic [1:0] em);
    wait_step();
    chk({nm, "_led"}, led, el);
    chk({nm, "_mode"}, mode, em);
  endtask

  logic [7:0] rol_seq [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
  logic [7:0] ror_seq [8]  = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
  logic [7:0] ping_seq [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    repeat (2) @(negedge clki);
    rs = 1'b0;
    // Idle mode: led stays off; then an async reset pulse while tick is high
    step_expect("off", 8'h00, 2'b00);
    for (int i = 0; i < 3 * DIV && !tick; i++) @(negedge clki);
    chk("tick_seen", tick, 1);
    #2 rs = 1'b1;
    #1;
    chk("async_tick", tick, 0);
    chk("async_led", led, 8'h00);
    chk("async_mode", mode, 2'b00);
    #9 rs = 1'b0;
    @(negedge clki);

    wait_step();
    {S1, S0} = 2'b01;
    step_expect("rol_start", 8'h01, 2'b01);
    foreach (rol_seq[i]) step_expect("rol", rol_seq[i], 2'b01);

    {S1, S0} = 2'b10;
    step_expect("ror_start", 8'h80, 2'b10);
    foreach (ror_seq[i]) step_expect("ror", ror_seq[i], 2'b10);

    {S1, S0} = 2'b11;
    foreach (ping_seq[i]) step_expect("ping", ping_seq[i], 2'b11);

    // Mid-pattern change from rotate-left at led=10
    {S1, S0} = 2'b01;
    step_expect("mid_start", 8'h01, 2'b01);
    for (int i = 0; i < 4; i++) wait_step();
    chk("mid_at10", led, 8'h10);
    {S1, S0} = 2'b10;
    step_expect("mid_switch", 8'h80, 2'b10);
    {S1, S0} = 2'b11;
    @(negedge clki);
    {S1, S0} = 2'b10;
    step_expect("glitch", 8'h40, 2'b10);

    // Reset during ping-pong on the way down
    {S1, S0} = 2'b11;
    for (int i = 0; i < 9; i++) wait_step();
    chk("pp_at40", led, 8'h40);
    #3 rs = 1'b1;
    #1;
    chk("pp_rst_led", led, 8'h00);
    chk("pp_rst_mode", mode, 2'b00);
    #6 rs = 1'b0;
    step_expect("pp_restart", 8'h01, 2'b11);
    step_expect("pp_second", 8'h02, 2'b11);

    // Random switching, short glitches and occasional resets
    for (int k = 0; k < 80; k++) begin
      int r;
      repeat ($urandom_range(1, 6)) @(negedge clki);
      r = $urandom_range(0, 9);
      if (r < 7) begin
        {S1, S0} = 2'($urandom_range(0, 3));
      end else if (r < 9) begin
        logic [1:0] keep;
        keep = {S1, S0};
        {S1, S0} = 2'($urandom_range(0, 3));
        @(negedge clki);
        {S1, S0} = keep;
      end else begin
        #3 rs = 1'b1;
        #1;
        chk("rnd_rst_led", led, 8'h00);
        chk("rnd_rst_tick", tick, 0);
        #($urandom_range(3, 10)) rs = 1'b0;
      end
    end
    repeat (3 * DIV) @(negedge clki);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
